ring_mem_responder: RTL
=======================

// Module: ring_mem_responder
// PURPOSE
// - Memory-side ring node: the target end of the Address/WriteData protocol that ring initiators (copier, RISC cores) drive.
// - Snoops the ring, captures 8-word write bursts, queues read-line requests and returns 8-word lines on RDreturn/RDdest.
// - Backed by on-chip line RAM; used as the memory model in small builds and in ring-level simulation.
// - Ring is passed through unmodified: RingOut=RingIn, SlotTypeOut=SlotTypeIn, SourceOut=SourceIn, combinationally.
// PARAMETERS
// - LINE_AW     10   line-address bits implemented (depth = 2**LINE_AW lines of 8x32b); upper address bits ignored (alias)
// - RQ_DEPTH    8    read-request FIFO depth (power of 2)
// - READ_DELAY  4    idle cycles from dequeue to first return word (>=1)
// - IDLE_DEST   4'hF RDdest value when no data is returned
// PORTS
// - clock       in   1   single clock
// - reset       in   1   synchronous, active-high
// - RingIn      in   32  ring data
// - SlotTypeIn  in   4   slot type (Token=1, Address=2, WriteData=3, Null=7)
// - SourceIn    in   4   core id driving the slot
// - RingOut     out  32  = RingIn
// - SlotTypeOut out  4   = SlotTypeIn
// - SourceOut   out  4   = SourceIn
// - RDreturn    out  32  read-return data word
// - RDdest      out  4   destination core of RDreturn; IDLE_DEST when idle
// - rqOverflow  out  1   sticky: read request dropped (FIFO full)
// - wrError     out  1   sticky: write Address seen with WriteData count != 8
// - rdCount     out  16  reads completed (MEMRESP_STATS_EN only, else 0)
// - wrCount     out  16  lines written (MEMRESP_STATS_EN only, else 0)
// BEHAVIOUR
// - Address slot: RingIn[31:28]==4'b0001 -> read of line RingIn[27:0]; ==4'b0000 -> write; other values ignored.
// - WriteData slot: word stored to wbuf[wcnt], wcnt(3b)+1; wcnt saturates flag 'wfull' after 8th word.
// - Write Address: if exactly 8 words held, all 8 written to line RAM in the next cycle (8 banks, one write);
//   else drop, set wrError. wcnt/wfull cleared either way. Next burst's WriteData may arrive the following cycle.
// - Read Address: push {line, SourceIn} to FIFO; if full, drop and set rqOverflow. Push+pop same cycle allowed when full.
// - Read engine FSM: IDLE -> (FIFO nonempty) pop, DELAY (READ_DELAY cycles; line RAM read in last) -> BURST (8 cycles) -> IDLE.
//   BURST: RDdest=source, RDreturn=word k, k=0..7, consecutive cycles, no gaps. From BURST k=7 with FIFO nonempty go straight to DELAY.
// - Data is sampled at RAM read time: a write committed before the RAM read cycle is visible; RA and WA of one token visit
//   to the same line is not a supported ordering.
// - RDdest/RDreturn registered; RDreturn=0 and RDdest=IDLE_DEST outside BURST.
// - Read latency: RA on ring cycle t (FIFO empty, engine idle) -> first word at t+2+READ_DELAY.
// - Reset: FIFO, wcnt, FSM, sticky flags, counters cleared; RDdest=IDLE_DEST, RDreturn=0 next cycle;
//   in-flight burst aborted; RAM contents retained.
// - Counters wrap at 16'hFFFF -> 0.
// CONFIGURATION
// - MEMRESP_STATS_EN defined: rdCount +1 on each completed burst (k=7), wrCount +1 on each committed write.
// - Undefined: counter logic absent, rdCount/wrCount tied to 0; all else identical.
// TESTING
// - 8xWD 0x10..0x17, WA 0x0000_0040 from src 3; RA 0x1000_0040 from src 5 -> 8 cycles RDdest=5, RDreturn 0x10..0x17 in order.
// - sendBoth pattern: RA 0x1000_0020 (src 2), 8xWD, WA 0x0000_0080 -> line 0x20 returned to 2; line 0x80 written; no errors.
// - RQ_DEPTH+2 RAs back-to-back with engine busy -> first RQ_DEPTH+1 served in order (src preserved), last dropped, rqOverflow=1.
// - 5xWD then WA -> RAM unchanged, wrError=1; following full 8-word burst commits correctly.
// - reset asserted during BURST word 3 -> next cycle RDdest=IDLE_DEST, FIFO empty; later read returns pre-reset RAM data.
// - Two queued reads (src 1, src 4) -> bursts separated by exactly READ_DELAY cycles; MEMRESP_STATS_EN: rdCount=2.

Source files
------------

// File: rtl/ring_mem_responder.sv
// Memory-side ring target: snoops write bursts into line RAM and serves queued 8-word line reads.
// Optional statistics counters are built when MEMRESP_STATS_EN is defined.
module ring_mem_responder #(
  parameter int          LINE_AW    = 10,
  parameter int          RQ_DEPTH   = 8,
  parameter int          READ_DELAY = 4,
  parameter logic [3:0]  IDLE_DEST  = 4'hF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] RingIn,
  input  logic [3:0]  SlotTypeIn,
  input  logic [3:0]  SourceIn,
  output logic [31:0] RingOut,
  output logic [3:0]  SlotTypeOut,
  output logic [3:0]  SourceOut,
  output logic [31:0] RDreturn,
  output logic [3:0]  RDdest,
  output logic        rqOverflow,
  output logic        wrError,
  output logic [15:0] rdCount,
  output logic [15:0] wrCount
);

  localparam int QW  = $clog2(RQ_DEPTH);
  localparam int DLW = (READ_DELAY > 1) ? $clog2(READ_DELAY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_BURST} state_t;

  assign RingOut     = RingIn;
  assign SlotTypeOut = SlotTypeIn;
  assign SourceOut   = SourceIn;

  logic              is_addr_s, is_wd_s, is_ra_s, is_wa_s, commit_s;
  logic [LINE_AW-1:0] addr_line_s;
  logic              unused_s;

  assign is_addr_s   = (SlotTypeIn == 4'd2);
  assign is_wd_s     = (SlotTypeIn == 4'd3);
  assign is_ra_s     = is_addr_s && (RingIn[31:28] == 4'b0001);
  assign is_wa_s     = is_addr_s && (RingIn[31:28] == 4'b0000);
  assign addr_line_s = RingIn[LINE_AW-1:0];
  assign unused_s    = &{1'b0, RingIn[27:LINE_AW]};

  logic [7:0][31:0]   mem [2**LINE_AW];
  logic [7:0][31:0]   wbuf_r;
  logic [2:0]         wcnt_r;
  logic               wfull_r, wover_r, wr_err_r;

  // A burst commits only when exactly eight words arrived; a ninth word marks overrun
  assign commit_s = is_wa_s && wfull_r && !wover_r;

  // Write-data capture and write-error tracking
  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt_r   <= 3'd0;
      wfull_r  <= 1'b0;
      wover_r  <= 1'b0;
      wr_err_r <= 1'b0;
    end else if (is_wd_s) begin
      if (wfull_r) begin
        wover_r <= 1'b1;
      end else begin
        wbuf_r[wcnt_r] <= RingIn;
        wcnt_r         <= wcnt_r + 3'd1;
        if (wcnt_r == 3'd7) wfull_r <= 1'b1;
      end
    end else if (is_wa_s) begin
      wcnt_r  <= 3'd0;
      wfull_r <= 1'b0;
      wover_r <= 1'b0;
      if (!commit_s) wr_err_r <= 1'b1;
    end
  end

  // Line RAM write port (contents survive reset)
  always_ff @(posedge clock) begin
    if (!reset && commit_s) mem[addr_line_s] <= wbuf_r;
  end

  logic [LINE_AW-1:0] fifo_line [RQ_DEPTH];
  logic [3:0]         fifo_src  [RQ_DEPTH];
  logic [QW:0]        wr_ptr_r, rd_ptr_r, level_s;
  logic               empty_s, full_s, pop_s, push_s, ovf_r;

  assign level_s = wr_ptr_r - rd_ptr_r;
  assign empty_s = (level_s == '0);
  assign full_s  = (level_s == (QW+1)'(RQ_DEPTH));
  assign push_s  = is_ra_s && (!full_s || pop_s);

  // Request FIFO storage
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_line[wr_ptr_r[QW-1:0]] <= addr_line_s;
      fifo_src[wr_ptr_r[QW-1:0]]  <= SourceIn;
    end
  end

  // Request FIFO pointers and sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + (QW+1)'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + (QW+1)'(1);
      if (is_ra_s && !push_s) ovf_r <= 1'b1;
    end
  end

  state_t             state_r, state_n;
  logic [DLW-1:0]     dly_r;
  logic [2:0]         k_r;
  logic [LINE_AW-1:0] line_r;
  logic [3:0]         src_r;
  logic [7:0][31:0]   rdata_r;
  logic [31:0]        rdret_r;
  logic [3:0]         rddest_r;
  logic               load_s;

  // Read engine next-state and FIFO pop
  always_comb begin
    state_n = state_r;
    pop_s   = 1'b0;
    load_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_n = S_DELAY;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_DELAY: begin
        if (dly_r == DLW'(READ_DELAY - 1)) begin
          load_s  = 1'b1;
          state_n = S_BURST;
        end else begin
          state_n = S_DELAY;
        end
      end
      S_BURST: begin
        if (k_r == 3'd7) begin
          if (!empty_s) begin
            pop_s   = 1'b1;
            state_n = S_DELAY;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          state_n = S_BURST;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Read engine registers; the line is sampled from RAM in the last delay cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= S_IDLE;
      dly_r    <= '0;
      k_r      <= 3'd0;
      line_r   <= '0;
      src_r    <= 4'd0;
      rdata_r  <= '0;
      rdret_r  <= 32'd0;
      rddest_r <= IDLE_DEST;
    end else begin
      state_r <= state_n;
      if (pop_s) begin
        line_r <= fifo_line[rd_ptr_r[QW-1:0]];
        src_r  <= fifo_src[rd_ptr_r[QW-1:0]];
        dly_r  <= '0;
      end else if (state_r == S_DELAY) begin
        dly_r  <= dly_r + DLW'(1);
      end
      if (load_s) begin
        rdata_r  <= mem[line_r];
        rdret_r  <= mem[line_r][0];
        rddest_r <= src_r;
        k_r      <= 3'd0;
      end else if (state_r == S_BURST && k_r != 3'd7) begin
        rdret_r  <= rdata_r[k_r + 3'd1];
        k_r      <= k_r + 3'd1;
      end else begin
        rdret_r  <= 32'd0;
        rddest_r <= IDLE_DEST;
      end
    end
  end

  assign RDreturn   = rdret_r;
  assign RDdest     = rddest_r;
  assign rqOverflow = ovf_r;
  assign wrError    = wr_err_r;

`ifdef MEMRESP_STATS_EN
  logic [15:0] rd_cnt_r, wr_cnt_r;

  // Completed-burst and committed-write counters, wrapping
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_cnt_r <= 16'd0;
      wr_cnt_r <= 16'd0;
    end else begin
      if (state_r == S_BURST && k_r == 3'd7) rd_cnt_r <= rd_cnt_r + 16'd1;
      if (commit_s) wr_cnt_r <= wr_cnt_r + 16'd1;
    end
  end

  assign rdCount = rd_cnt_r;
  assign wrCount = wr_cnt_r;
`else
  assign rdCount = 16'd0;
  assign wrCount = 16'd0;
`endif

endmodule
